ram64_block_mover: RTL

- Upstream sequencer that owns the single port of a RAM64 instance (in/load/address/out).
- While IDLE it passes a host port straight through to the RAM.
- On command it performs either a block FILL (constant value) or a block COPY (src→dst) over up to 64 words.
- Asserts busy while working and pulses done when finished; the RAM64 instance is placed by the parent.

---
 rtl/ram64_block_mover_pkg.sv | 19 +
 rtl/ram64_block_mover_if.sv | 35 +++
 rtl/ram64_block_mover.sv | 109 ++++++++++
 3 files changed

// File: rtl/ram64_block_mover_pkg.sv
// Shared constants and state encoding for the RAM64 block mover.
// Default widths describe a 64-word, 16-bit RAM.
package ram_mover_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 7;
  localparam int MAX_LEN    = 2**DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;
endpackage

// File: rtl/ram64_block_mover_if.sv
// Command, host pass-through and RAM-port bundle for the block mover.
// master = parent/host side, slave = the mover itself.
interface ram64_block_mover_if import ram_mover_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              start;
  logic              op;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_val;
  logic [DATA_W-1:0] host_in;
  logic              host_load;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_out;
  logic              host_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_out;

  modport master (
    output start, op, src, dst, len, fill_val, host_in, host_load, host_addr, mem_out,
    input  host_out, host_ready, busy, done, mem_in, mem_load, mem_addr
  );

  modport slave (
    input  start, op, src, dst, len, fill_val, host_in, host_load, host_addr, mem_out,
    output host_out, host_ready, busy, done, mem_in, mem_load, mem_addr
  );
endinterface

// File: rtl/ram64_block_mover.sv
// Sequencer owning a RAM64 port: host pass-through in IDLE, block FILL or
// forward block COPY otherwise. The RAM itself is instantiated by the parent.
module ram64_block_mover import ram_mover_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input logic CLK,
  input logic reset,
  ram64_block_mover_if.slave bus
);
  localparam int MAX_WORDS = 2**ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  cnt_q, len_sat;
  logic [DATA_W-1:0] fill_q, data_q;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load, busy, done, host_ready;

  assign len_sat = (bus.len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : bus.len;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.start) begin
          src_q  <= bus.src;
          dst_q  <= bus.dst;
          fill_q <= bus.fill_val;
          cnt_q  <= len_sat;
        end
        FILL, WR: begin
          dst_q <= dst_q + ADDR_W'(1);
          cnt_q <= cnt_q - LEN_W'(1);
        end
        RD: begin
          data_q <= bus.mem_out;
          src_q  <= src_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr   = bus.host_addr;
    mem_in     = bus.host_in;
    mem_load   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    host_ready = 1'b0;
    case (state_q)
      IDLE: begin
        host_ready = 1'b1;
        mem_load   = bus.host_load;
        if (bus.start) begin
          if (len_sat == '0)          state_d = DONE;
          else if (bus.op == OP_COPY) state_d = RD;
          else                        state_d = FILL;
        end
      end
      FILL: begin
        busy     = 1'b1;
        mem_addr = dst_q;
        mem_in   = fill_q;
        mem_load = 1'b1;
        if (cnt_q == LEN_W'(1)) state_d = DONE;
      end
      RD: begin
        busy     = 1'b1;
        mem_addr = src_q;
        state_d  = WR;
      end
      WR: begin
        busy     = 1'b1;
        mem_addr = dst_q;
        mem_in   = data_q;
        mem_load = 1'b1;
        state_d  = (cnt_q == LEN_W'(1)) ? DONE : RD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a reset cycle must never commit a write, whatever the state drives
    if (reset) mem_load = 1'b0;
  end

  assign bus.mem_addr   = mem_addr;
  assign bus.mem_in     = mem_in;
  assign bus.mem_load   = mem_load;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.host_ready = host_ready;
  assign bus.host_out   = bus.mem_out;
endmodule
